uart_byte_receiver: RTL and testbench
=====================================

// Module: uart_byte_receiver
// PURPOSE
//  Serial-to-byte front end of the Bluetooth programming path: oversamples the raw uart_rx pin (PIN_AC18),
//  rebuilds 8N1 frames and hands each good byte to the UART programmer as a one-cycle strobe.
//  Sits directly upstream of the word assembler that drives prog_addr/prog_data/prog_we into the RISC-V core.
// PARAMETERS
//  CLK_FREQ    50000000  system clock frequency, Hz
//  BAUD_RATE   115200    line rate, bit/s
//  OVERSAMPLE  16        ticks per bit; DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer-truncated (27 at defaults), must be >=1
//  PARITY_ODD  0         0 = even, 1 = odd; used only when UART_RX_PARITY_EN is defined
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  reset, active-low
//  rx          in   1  asynchronous serial input, idle high
//  rx_data     out  8  last good byte, LSB received first; holds until next good byte
//  rx_valid    out  1  one-clk pulse: rx_data updated this cycle
//  frame_err   out  1  one-clk pulse: stop bit sampled low
//  parity_err  out  1  one-clk pulse: parity mismatch (tied 0 when feature compiled out)
//  busy        out  1  high from start-edge detection until return to IDLE
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset: rx_data=8'h00, rx_valid=0, frame_err=0, parity_err=0, busy=0, FSM=IDLE, sync FFs=1, counters=0.
//   Reset mid-frame aborts the frame silently; no strobe is issued.
//  rx passes through a 2-FF synchronizer (reset value 1); all logic uses the synchronized rx_s.
//  Tick divider counts 0..DIV-1 and asserts tick on DIV-1. It is cleared on start-edge detection so bit phase aligns to the edge.
//  A 4-bit tick_cnt counts 0..OVERSAMPLE-1 within each bit. Bit value = majority of rx_s at ticks 7, 8, 9.
//  FSM:
//   IDLE      rx_s==0 -> START (busy=1, clear divider and tick_cnt).
//   START     on tick 9: majority 1 (glitch) -> IDLE; else -> DATA with bit_idx=0.
//   DATA      decide at tick 9, shift into shift_reg[bit_idx]; after bit_idx==7 -> PARITY if enabled, else STOP.
//   PARITY    decide at tick 9; store mismatch flag -> STOP.
//   STOP      decide at tick 9: 1 -> rx_data<=shift_reg, rx_valid=1 (and parity_err=flag), -> IDLE.
//             0 -> frame_err=1, rx_data unchanged, -> BREAK.
//   BREAK     wait for rx_s==1 -> IDLE (no new start edge accepted while line low).
//  Returning to IDLE at stop tick 9 lets a back-to-back start edge half a bit later be caught; no idle gap is required.
//  All strobes are single-cycle and mutually exclusive with respect to rx_valid/frame_err. There is no backpressure.
//   The consumer must take the byte on the rx_valid cycle.
//  Latency: rx_valid rises about 9.5 bit times + 2 clk after the start falling edge at the pin.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: 8E1/8O1 frames (per PARITY_ODD). PARITY state is inserted.
//   On a parity mismatch, parity_err pulses with rx_valid and the byte is still delivered.
//  Not defined: 8N1 only. PARITY state is unreachable and removed; parity_err is driven constant 0.
// STRUCTURE
//  uart_pkg: typedef enum {IDLE,START,DATA,PARITY,STOP,BREAK} uart_rx_state_t;
//   localparam OVERSAMPLE_DEFAULT=16, SAMPLE_LO=7, SAMPLE_MID=8, SAMPLE_HI=9;
//   function uart_div(clk_freq, baud, os).
//  Sub-module uart_baud_tick (divider plus sync clear, one-cycle tick out).
//   It is reused later by the TX echo path.
// TESTING (defaults, 8.68 us/bit)
//  1) Send 0x55 8N1 -> one rx_valid, rx_data=8'h55, frame_err=0, busy low ~1/2 bit after stop mid.
//  2) rx low for 4 ticks then high -> no strobe, FSM back to IDLE, busy pulses only.
//  3) Send 0xA5 with stop bit 0 -> frame_err pulse, no rx_valid, rx_data keeps prior value.
//     Line held low 3 bits -> no frame is decoded until rx high.
//  4) Send 0xA5 then 0x3C with zero idle gap -> two rx_valid pulses, 8'hA5 then 8'h3C.
//  5) Assert rst_n low during bit 4 of 0xFF -> all outputs 0 at once, no strobe.
//     Next frame 0x81 -> rx_valid with 8'h81.
//  6) (UART_RX_PARITY_EN, PARITY_ODD=0) send 0x07 with parity bit 0 -> rx_valid and parity_err same cycle, rx_data=8'h07.
//     With parity bit 1 -> rx_valid only.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path and its baud divider.
// Compile with UART_RX_PARITY_EN defined to enable the parity stage in uart_byte_receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_rx_state_t;

    localparam int OVERSAMPLE_DEFAULT = 16;
    localparam int SAMPLE_LO  = 7;
    localparam int SAMPLE_MID = 8;
    localparam int SAMPLE_HI  = 9;

    // Clocks per oversample tick, truncated, never below 1.
    function automatic int uart_div(input int clk_freq, input int baud, input int os);
        int d;
        d = clk_freq / (baud * os);
        if (d < 1) d = 1;
        return d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: counts 0..DIV-1, tick is high while the count sits at DIV-1.
// A synchronous clear realigns the phase to an external event (e.g. a start edge).
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CNT_LAST) && !clear;

endmodule

// File: rtl/uart_byte_receiver.sv
// Oversampling 8N1 UART receiver producing one-cycle byte / error strobes.
// Define UART_RX_PARITY_EN for 8E1/8O1 frames (PARITY_ODD selects odd).
module uart_byte_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int DIV = uart_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

    logic           rx_meta;
    logic           rx_s;
    uart_rx_state_t state;
    logic [3:0]     tick_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shift_reg;
    logic           sample_lo;
    logic           sample_mid;
    logic           tick;
    logic           start_edge;
    logic           decide;
    logic           bit_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign start_edge = (state == IDLE) && !rx_s;

    uart_baud_tick #(.DIV(DIV)) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_edge),
        .tick  (tick)
    );

    // Samples at ticks 7 and 8 are held; tick 9 uses the live rx_s.
    assign decide  = tick && (tick_cnt == 4'(SAMPLE_HI));
    assign bit_val = (sample_lo & sample_mid) | (sample_lo & rx_s) | (sample_mid & rx_s);

`ifdef UART_RX_PARITY_EN
    logic par_flag;
    logic par_expect;
    assign par_expect = (^shift_reg) ^ (PARITY_ODD != 0);
`else
    assign parity_err = 1'b0;
`endif

    // rx_valid has no backpressure: the consumer must capture rx_data in the strobe cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            sample_lo  <= 1'b1;
            sample_mid <= 1'b1;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_flag   <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (start_edge) begin
                tick_cnt <= '0;
            end else if (tick) begin
                tick_cnt <= (tick_cnt == TICK_LAST) ? 4'd0 : tick_cnt + 4'd1;
                if (tick_cnt == 4'(SAMPLE_LO))  sample_lo  <= rx_s;
                if (tick_cnt == 4'(SAMPLE_MID)) sample_mid <= rx_s;
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (decide) begin
                        if (bit_val) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end
                end
                DATA: begin
                    if (decide) begin
                        shift_reg[bit_idx] <= bit_val;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (decide) begin
                        par_flag <= (bit_val != par_expect);
                        state    <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (decide) begin
                        if (bit_val) begin
                            rx_data  <= shift_reg;
                            rx_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err <= par_flag;
`endif
                            state    <= IDLE;
                            busy     <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Directed bench for uart_byte_receiver: stimulus pushes expected strobes, a monitor pops and compares.
// Honours UART_RX_PARITY_EN so the same file covers both builds.
module tb_uart_byte_receiver;

    localparam int  BIT_CLKS  = 432;  // 16 ticks * 27 clocks at the default parameters
    localparam int  TICK_CLKS = 27;
`ifdef UART_RX_PARITY_EN
    localparam bit  PAR_EN = 1'b1;
`else
    localparam bit  PAR_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    // {frame_err, parity_err, rx_data}
    logic [9:0] exp_q[$];
    logic [7:0] last_good;
    int         n_vec;
    int         n_err;

    uart_byte_receiver #(
        .CLK_FREQ   (50000000),
        .BAUD_RATE  (115200),
        .OVERSAMPLE (16),
        .PARITY_ODD (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n && (rx_valid || frame_err)) begin
            if (rx_valid && frame_err) begin
                check("strobe_exclusive", 32'({rx_valid, frame_err}), 32'b10);
            end else if (exp_q.size() == 0) begin
                check("unexpected_strobe", 32'({frame_err, parity_err, rx_data}), 32'h3ff);
            end else begin
                check("strobe", 32'({frame_err, parity_err, rx_data}), 32'(exp_q.pop_front()));
            end
        end
    end

    // driver tasks
    task automatic drive_bit(input logic b);
        @(negedge clk);
        rx = b;
        repeat (BIT_CLKS - 1) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR_EN) drive_bit(par_bit);
        drive_bit(stop_bit);
    endtask

    task automatic send_good(input logic [7:0] d);
        exp_q.push_back({2'b00, d});
        last_good = d;
        send_frame(d, ^d, 1'b1);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        last_good = 8'h00;
        rx        = 1'b1;
        rst_n     = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_outputs", 32'({rx_data, rx_valid, frame_err, parity_err, busy}), 32'h0);
        rst_n = 1'b1;
        idle_bits(1);
        check("idle_busy", 32'(busy), 32'h0);

        // 1) plain byte; busy must already be low at the end of the stop bit
        send_good(8'h55);
        check("busy_after_55", 32'(busy), 32'h0);

        // 2) short glitch: ~4 ticks low, rejected at start mid-bit
        @(negedge clk);
        rx = 1'b0;
        repeat (4 * TICK_CLKS) @(negedge clk);
        rx = 1'b1;
        check("glitch_busy_high", 32'(busy), 32'h1);
        idle_bits(1);
        check("glitch_busy_low", 32'(busy), 32'h0);

        // 3) framing error, then line held low 3 bits
        exp_q.push_back({2'b10, last_good});
        send_frame(8'hA5, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (3 * BIT_CLKS) @(negedge clk);
        check("break_busy", 32'(busy), 32'h1);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check("break_release", 32'(busy), 32'h0);
        idle_bits(1);

        // 4) back-to-back frames with no idle gap, plus boundary bytes
        send_good(8'hA5);
        send_good(8'h3C);
        send_good(8'h00);
        send_good(8'hFF);
        send_good(8'h80);
        idle_bits(1);

        // 5) reset during bit 4 of 0xFF
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        repeat (200) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midframe_reset", 32'({rx_data, rx_valid, frame_err, parity_err, busy}), 32'h0);
        last_good = 8'h00;
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        idle_bits(1);
        check("post_reset_busy", 32'(busy), 32'h0);
        send_good(8'h81);

`ifdef UART_RX_PARITY_EN
        // 6) even parity: 0x07 needs parity bit 1
        idle_bits(1);
        exp_q.push_back({2'b01, 8'h07});
        send_frame(8'h07, 1'b0, 1'b1);
        exp_q.push_back({2'b00, 8'h07});
        send_frame(8'h07, 1'b1, 1'b1);
`endif

        for (int i = 0; i < 2 * BIT_CLKS && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #4ms;
        $display("FAIL watchdog: simulation exceeded time limit, %0d pending", exp_q.size());
        $fatal(1, "watchdog");
    end

endmodule
